// File: rtl/sr_pulse_gen.sv
// Debounced set/reset pulse generator: two bouncing buttons in, one-cycle S/R pulses out.
// Latency DEBOUNCE+2 edges from first clean sample; no backpressure; define SR_CONFLICT_EN for the conflict output.
module sr_pulse_gen #(
    parameter int DEBOUNCE = 4,
    parameter int CNT_W    = $clog2(DEBOUNCE) + 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_set,
    input  logic btn_rst,
    output logic S,
    output logic R
`ifdef SR_CONFLICT_EN
    ,
    output logic conflict
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        HELD   = 2'd2,
        DISARM = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Channel 0 is set, channel 1 is reset.
    logic [1:0]       sync1_q, sync1_d;
    logic [1:0]       sync2_q, sync2_d;
    state_t           state_q [2];
    state_t           state_d [2];
    logic [CNT_W-1:0] cnt_q   [2];
    logic [CNT_W-1:0] cnt_d   [2];
    logic [1:0]       pulse;
    logic             s_q, s_d;
    logic             r_q, r_d;
    logic             conflict_q, conflict_d;

    always_comb begin
        sync1_d = {btn_rst, btn_set};
        sync2_d = sync1_q;
        pulse   = 2'b00;
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                IDLE: begin
                    if (sync2_q[i]) begin
                        state_d[i] = ARM;
                        cnt_d[i]   = CNT_ONE;
                    end
                end
                ARM: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_MAX) begin
                        state_d[i] = HELD;
                        cnt_d[i]   = '0;
                        pulse[i]   = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                HELD: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = DISARM;
                        cnt_d[i]   = CNT_ONE;
                    end
                end
                DISARM: begin
                    if (sync2_q[i]) begin
                        state_d[i] = HELD;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_MAX) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
        // Reset wins a same-cycle collision; the set pulse is dropped outright.
        r_d        = pulse[1];
        s_d        = pulse[0] & ~pulse[1];
        conflict_d = pulse[0] & pulse[1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            state_q[0] <= IDLE;
            state_q[1] <= IDLE;
            cnt_q[0]   <= '0;
            cnt_q[1]   <= '0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            state_q[0] <= state_d[0];
            state_q[1] <= state_d[1];
            cnt_q[0]   <= cnt_d[0];
            cnt_q[1]   <= cnt_d[1];
            s_q        <= s_d;
            r_q        <= r_d;
            conflict_q <= conflict_d;
        end
    end

    assign S = s_q;
    assign R = r_q;
`ifdef SR_CONFLICT_EN
    assign conflict = conflict_q;
`else
    logic unused_conflict;
    assign unused_conflict = conflict_q;
`endif

endmodule

// File: tb/tb_sr_pulse_gen.sv
// Scoreboarded bench for sr_pulse_gen with DEBOUNCE=4: expected pulses queued by stimulus, checked by a monitor.
module tb_sr_pulse_gen;

    logic clk = 1'b0;
    logic rst_n;
    logic btn_set;
    logic btn_rst;
    logic S;
    logic R;
    logic conflict_w;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    typedef struct {
        int   edge_no;
        logic s;
        logic r;
        logic c;
    } exp_t;

    exp_t exp_q[$];

    sr_pulse_gen #(.DEBOUNCE(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_set (btn_set),
        .btn_rst (btn_rst),
        .S       (S),
        .R       (R)
`ifdef SR_CONFLICT_EN
        ,
        .conflict(conflict_w)
`endif
    );

`ifndef SR_CONFLICT_EN
    assign conflict_w = 1'b0;
`endif

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, cyc);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Expect a pulse DEBOUNCE+2 = 6 edges after the next rising edge.
    task automatic expect_pulse(input logic s, input logic r, input logic c);
        exp_t e;
        e.edge_no = cyc + 1 + 6;
        e.s       = s;
        e.r       = r;
        e.c       = c;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (S || R || conflict_w) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {29'd0, conflict_w, S, R}, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_edge", cyc, e.edge_no);
                    check("pulse_S", int'(S), int'(e.s));
                    check("pulse_R", int'(R), int'(e.r));
`ifdef SR_CONFLICT_EN
                    check("pulse_conflict", int'(conflict_w), int'(e.c));
`endif
                end
            end
        end
    end

    initial begin : stim
        rst_n   = 1'b1;
        btn_set = 1'b0;
        btn_rst = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("reset_S", int'(S), 0);
        check("reset_R", int'(R), 0);
        check("reset_conflict", int'(conflict_w), 0);
        wait_neg(3);
        rst_n = 1'b1;
        wait_neg(3);

        // Held set press: one pulse, nothing more while held.
        btn_set = 1'b1;
        expect_pulse(1'b1, 1'b0, 1'b0);
        wait_neg(100);
        btn_set = 1'b0;
        wait_neg(20);

        // Bouncing reset followed by a clean hold.
        btn_rst = 1'b1; wait_neg(1);
        btn_rst = 1'b0; wait_neg(1);
        btn_rst = 1'b1; wait_neg(1);
        btn_rst = 1'b0; wait_neg(1);
        btn_rst = 1'b1;
        expect_pulse(1'b0, 1'b1, 1'b0);
        wait_neg(20);
        btn_rst = 1'b0;
        wait_neg(20);

        // Simultaneous presses: reset wins, set dropped.
        btn_set = 1'b1;
        btn_rst = 1'b1;
        expect_pulse(1'b0, 1'b1, 1'b1);
        wait_neg(20);
        btn_set = 1'b0;
        btn_rst = 1'b0;
        wait_neg(20);

        // Reset mid-ARM discards the count; held button re-qualifies afterwards.
        btn_set = 1'b1;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midreset_S", int'(S), 0);
        check("midreset_R", int'(R), 0);
        wait_neg(3);
        check("midreset_hold_S", int'(S), 0);
        rst_n = 1'b1;
        expect_pulse(1'b1, 1'b0, 1'b0);
        wait_neg(20);
        btn_set = 1'b0;
        wait_neg(20);

        // Short release keeps HELD; long release re-arms.
        btn_set = 1'b1;
        expect_pulse(1'b1, 1'b0, 1'b0);
        wait_neg(10);
        btn_set = 1'b0;
        wait_neg(2);
        btn_set = 1'b1;
        wait_neg(10);
        btn_set = 1'b0;
        wait_neg(10);
        btn_set = 1'b1;
        expect_pulse(1'b1, 1'b0, 1'b0);
        wait_neg(20);
        btn_set = 1'b0;
        wait_neg(20);

        check("missing_pulses", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sr_pulse_gen.md
SR_PULSE_GEN -- requirements
Module: sr_pulse_gen

Interface
REQ-001 Parameter DEBOUNCE, default 4: number of consecutive synchronized samples an input must hold before it counts as a level change; legal range 2..65535.
REQ-002 Parameter CNT_W, default $clog2(DEBOUNCE)+1: width of each debounce counter.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port btn_set, input, 1 bit: raw, asynchronous, bouncing set request.
REQ-006 Port btn_rst, input, 1 bit: raw, asynchronous, bouncing reset request.
REQ-007 Port S, output, 1 bit: registered single-cycle set pulse for the downstream SR flip-flop.
REQ-008 Port R, output, 1 bit: registered single-cycle reset pulse for the downstream SR flip-flop.

Function
REQ-009 Each button SHALL pass through its own two-flop synchronizer before any other logic uses it.
REQ-010 Each channel SHALL run an independent four-state FSM: IDLE (stable low), ARM (counting high), HELD (stable high), DISARM (counting low).
REQ-011 IDLE -> ARM SHALL occur when the synchronized input is 1, with the counter loaded to 1.
REQ-012 In ARM, the counter SHALL increment on each sampled 1; a sampled 0 SHALL return the FSM to IDLE and clear the counter.
REQ-013 ARM -> HELD SHALL occur when the counter reaches DEBOUNCE with the input still 1; that transition alone SHALL generate the channel pulse.
REQ-014 HELD -> DISARM on a sampled 0; DISARM counts consecutive 0s, returns to HELD on a sampled 1, and goes to IDLE after DEBOUNCE consecutive 0s; no pulse SHALL be generated on release.
REQ-015 Latency: S (or R) SHALL assert exactly DEBOUNCE+2 rising edges after the first edge that samples a clean, held 1 on the raw input.
REQ-016 Each pulse SHALL be exactly one clk cycle wide; a held button SHALL generate exactly one pulse per press.
REQ-017 A glitch shorter than DEBOUNCE synchronized samples SHALL generate no pulse and leave the FSM in IDLE (or HELD, for a low glitch).
REQ-018 Simultaneous pulses (both channels in the same cycle) SHALL produce R=1, S=0; the set pulse is dropped, not deferred, so S and R are never both 1.
REQ-019 The counter SHALL saturate at DEBOUNCE and never wrap.

Reset
REQ-020 While rst_n=0, all of the following SHALL be cleared asynchronously and independently of clk: synchronizers to 0, both FSMs to IDLE, counters to 0, and S, R (and conflict) to 0.
REQ-021 Reset asserted mid-count SHALL discard the partial count; no pulse SHALL appear after reset for that press unless it is re-qualified.
REQ-022 A button held through reset release SHALL be treated as a new press and SHALL pulse DEBOUNCE+2 edges after the first post-release edge.

Configuration
REQ-023 With macro SR_CONFLICT_EN defined, the block SHALL add output port conflict (1 bit, registered), pulsed for one cycle in each cycle where REQ-018 drops a set pulse.
REQ-024 With SR_CONFLICT_EN undefined, the conflict port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification (DEBOUNCE=4)
REQ-025 Reset release, btn_set held 1 from edge 0 -> S=1 only in the cycle after edge 6; R stays 0; no further S while held for 100 cycles.
REQ-026 btn_rst toggles 1,0,1,0 on successive cycles, then holds 1 -> no R during the toggling; a single R pulse 6 edges after the hold begins.
REQ-027 Both buttons rise on the same edge and are held -> R=1 and S=0 in the same cycle; conflict=1 in that cycle only with SR_CONFLICT_EN defined.
REQ-028 btn_set held, rst_n pulsed low at edge 4 (mid-ARM) -> S, R and the FSMs clear immediately; S pulses 6 edges after rst_n returns high.
REQ-029 Press, release for 2 cycles (< DEBOUNCE), press again -> only one S pulse in total; release for 10 cycles then press -> a second S pulse.
